serpentine_scan_ctrl: RTL and testbench

Sequencer that drives the serpentine (boustrophedon) search walk for the motion-estimation datapath. It generates successive (X, Y) window positions, requests a SAD evaluation for each from the SAD unit over a Req/Ack handshake, and tracks the minimum SAD and its position. On completion it reports the best match. It sits between the instruction-level start command and the shared SAD evaluation unit, and replaces per-instruction stepping with a self-timed scan.

---
 rtl/serpentine_scan_ctrl_pkg.sv | 18 +
 rtl/serpentine_scan_ctrl_scan_step.sv | 33 +++
 rtl/serpentine_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_serpentine_scan_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serpentine_scan_ctrl_pkg.sv
// Shared types and constants for the serpentine search sequencer.
// Holds widths, the FSM state enum and the initial best-SAD value.
package serpentine_scan_ctrl_pkg;

  localparam int COORD_W = 16;
  localparam int SAD_W   = 32;
  localparam int CNT_W   = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_STEP,
    S_DONE
  } state_e;

  localparam logic [SAD_W-1:0] SAD_INIT = {SAD_W{1'b1}};

endpackage

// File: rtl/serpentine_scan_ctrl_scan_step.sv
// Next-position logic for the boustrophedon walk (combinational).
// Ports: i_x/i_y current, i_xmax/i_ymax limits; o_next_x/o_next_y, o_last.
module scan_step
  import serpentine_scan_ctrl_pkg::*;
(
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_xmax,
  input  logic [COORD_W-1:0] i_ymax,
  output logic [COORD_W-1:0] o_next_x,
  output logic [COORD_W-1:0] o_next_y,
  output logic               o_last
);

  logic               w_even;
  logic               w_row_end;
  logic [COORD_W-1:0] w_final_x;

  // Even rows run left to right, odd rows right to left.
  assign w_even    = ~i_y[0];
  assign w_row_end = w_even ? (i_x == i_xmax)
                            : (i_x == {COORD_W{1'b0}});

  assign o_next_y = w_row_end ? i_y + COORD_W'(1) : i_y;
  assign o_next_x = w_row_end ? i_x
                  : (w_even ? i_x + COORD_W'(1)
                            : i_x - COORD_W'(1));

  // The walk ends on the far side of the last row.
  assign w_final_x = i_ymax[0] ? {COORD_W{1'b0}} : i_xmax;
  assign o_last    = (i_y == i_ymax) && (i_x == w_final_x);

endmodule

// File: rtl/serpentine_scan_ctrl.sv
// Self-timed serpentine search: requests SADs, tracks the minimum.
// Ports: i_start/i_abort control, i_xmax/i_ymax limits, o_req/i_ack/i_sad
// handshake, o_x/o_y position, o_busy/o_done status, o_best_* and o_count.
module serpentine_scan_ctrl
  import serpentine_scan_ctrl_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [COORD_W-1:0] i_xmax,
  input  logic [COORD_W-1:0] i_ymax,
  output logic               o_req,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  input  logic               i_ack,
  input  logic [SAD_W-1:0]   i_sad,
  output logic               o_busy,
  output logic               o_done,
  output logic [COORD_W-1:0] o_best_x,
  output logic [COORD_W-1:0] o_best_y,
  output logic [SAD_W-1:0]   o_best_sad,
  output logic [CNT_W-1:0]   o_count
);

  state_e             r_state;
  logic               r_req;
  logic               r_busy;
  logic               r_done;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [COORD_W-1:0] r_xmax;
  logic [COORD_W-1:0] r_ymax;
  logic [COORD_W-1:0] r_best_x;
  logic [COORD_W-1:0] r_best_y;
  logic [SAD_W-1:0]   r_best_sad;
  logic [CNT_W-1:0]   r_count;

  logic [COORD_W-1:0] w_next_x;
  logic [COORD_W-1:0] w_next_y;
  logic               w_last;

  scan_step u_step (
    .i_x      (r_x),
    .i_y      (r_y),
    .i_xmax   (r_xmax),
    .i_ymax   (r_ymax),
    .o_next_x (w_next_x),
    .o_next_y (w_next_y),
    .o_last   (w_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_xmax     <= '0;
      r_ymax     <= '0;
      r_best_x   <= '0;
      r_best_y   <= '0;
      r_best_sad <= '0;
      r_count    <= '0;
    end else if (r_state != S_IDLE && i_abort) begin
      // Abort beats a same-cycle Ack: no count or best update.
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start && !i_abort) begin
            r_xmax     <= i_xmax;
            r_ymax     <= i_ymax;
            r_x        <= '0;
            r_y        <= '0;
            r_count    <= '0;
            r_best_sad <= SAD_INIT;
            r_best_x   <= '0;
            r_best_y   <= '0;
            r_req      <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_ack) begin
            r_req <= 1'b0;
            if (r_count != {CNT_W{1'b1}})
              r_count <= r_count + CNT_W'(1);
            // Strict compare keeps the earliest minimum on ties.
            if (i_sad < r_best_sad) begin
              r_best_sad <= i_sad;
              r_best_x   <= r_x;
              r_best_y   <= r_y;
            end
            r_state <= S_STEP;
          end
        end
        S_STEP: begin
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_x     <= w_next_x;
            r_y     <= w_next_y;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req      = r_req;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_x        = r_x;
  assign o_y        = r_y;
  assign o_best_x   = r_best_x;
  assign o_best_y   = r_best_y;
  assign o_best_sad = r_best_sad;
  assign o_count    = r_count;

endmodule

// File: tb/tb_serpentine_scan_ctrl.sv
// Bench for serpentine_scan_ctrl and scan_step.
// Reference walk is built row by row from the limits.
module tb_serpentine_scan_ctrl;
  import serpentine_scan_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_start;
  logic               i_abort;
  logic [COORD_W-1:0] i_xmax;
  logic [COORD_W-1:0] i_ymax;
  logic               o_req;
  logic [COORD_W-1:0] o_x;
  logic [COORD_W-1:0] o_y;
  logic               i_ack;
  logic [SAD_W-1:0]   i_sad;
  logic               o_busy;
  logic               o_done;
  logic [COORD_W-1:0] o_best_x;
  logic [COORD_W-1:0] o_best_y;
  logic [SAD_W-1:0]   o_best_sad;
  logic [CNT_W-1:0]   o_count;

  logic [COORD_W-1:0] s_x;
  logic [COORD_W-1:0] s_y;
  logic [COORD_W-1:0] s_xm;
  logic [COORD_W-1:0] s_ym;
  logic [COORD_W-1:0] s_nx;
  logic [COORD_W-1:0] s_ny;
  logic               s_last;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  int px[$];
  int py[$];
  int fsad[$];
  int fdel[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serpentine_scan_ctrl dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .i_xmax     (i_xmax),
    .i_ymax     (i_ymax),
    .o_req      (o_req),
    .o_x        (o_x),
    .o_y        (o_y),
    .i_ack      (i_ack),
    .i_sad      (i_sad),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_best_x   (o_best_x),
    .o_best_y   (o_best_y),
    .o_best_sad (o_best_sad),
    .o_count    (o_count)
  );

  scan_step u_ss (
    .i_x      (s_x),
    .i_y      (s_y),
    .i_xmax   (s_xm),
    .i_ymax   (s_ym),
    .o_next_x (s_nx),
    .o_next_y (s_ny),
    .o_last   (s_last)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic void build(input int xm, input int ym);
    px.delete();
    py.delete();
    for (int y = 0; y <= ym; y++)
      for (int k = 0; k <= xm; k++) begin
        px.push_back((y % 2) ? xm - k : k);
        py.push_back(y);
      end
  endfunction

  task automatic run_scan(input int xm, input int ym,
                          input bit fixed, input int abort_at);
    int n, k, d, v, t0, lat, bx, by;
    logic [SAD_W-1:0] bsad;
    build(xm, ym);
    n = px.size();
    bsad = '1;
    bx = 0;
    by = 0;
    lat = 0;
    @(negedge clk);
    i_xmax = COORD_W'(xm);
    i_ymax = COORD_W'(ym);
    i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (!o_req && k < 10) begin
        @(negedge clk);
        k++;
      end
      chk("req", o_req, 1);
      chk("x", o_x, px[i]);
      chk("y", o_y, py[i]);
      d = fixed ? fdel[i] : int'($urandom_range(0, 3));
      v = fixed ? fsad[i] : int'($urandom_range(0, 15));
      for (int w = 0; w < d; w++) begin
        i_start = 1'($urandom % 2);
        @(negedge clk);
        chk("req_hold", o_req, 1);
        chk("x_hold", o_x, px[i]);
        chk("y_hold", o_y, py[i]);
      end
      i_start = 1'b0;
      if (i == abort_at) begin
        i_abort = 1'b1;
        i_ack = 1'b1;
        i_sad = '0;
        @(posedge clk);
        @(negedge clk);
        i_abort = 1'b0;
        i_ack = 1'b0;
        chk("abort_busy", o_busy, 0);
        chk("abort_req", o_req, 0);
        chk("abort_done", o_done, 0);
        chk("abort_count", o_count, i);
        chk("abort_best", o_best_sad, bsad);
        @(negedge clk);
        chk("abort_nodone", o_done, 0);
        return;
      end
      i_ack = 1'b1;
      i_sad = SAD_W'(v);
      @(posedge clk);
      @(negedge clk);
      i_ack = 1'b0;
      lat += d + 2;
      if (SAD_W'(v) < bsad) begin
        bsad = SAD_W'(v);
        bx = px[i];
        by = py[i];
      end
      chk("count", o_count, i + 1);
      chk("req_drop", o_req, 0);
      chk("busy", o_busy, 1);
    end
    @(negedge clk);
    k = 0;
    while (!o_done && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("done", o_done, 1);
    chk("latency", cyc - t0, lat);
    chk("best_sad", o_best_sad, bsad);
    chk("best_x", o_best_x, bx);
    chk("best_y", o_best_y, by);
    chk("count_end", o_count, n);
    @(negedge clk);
    chk("done_pulse", o_done, 0);
    chk("idle_busy", o_busy, 0);
    chk("hold_best", o_best_sad, bsad);
    chk("hold_count", o_count, n);
  endtask

  initial begin
    rst_n = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_ack = 1'b0;
    i_sad = '0;
    i_xmax = '0;
    i_ymax = '0;
    s_x = '0;
    s_y = '0;
    s_xm = '0;
    s_ym = '0;
    #1;
    chk("rst_outs",
        {o_req, o_busy, o_done, o_x, o_y, o_best_x, o_best_y},
        '0);
    chk("rst_sad", o_best_sad, 0);
    chk("rst_count", o_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    fsad = '{9, 7, 7, 3, 5, 3};
    fdel = '{0, 0, 0, 0, 0, 0};
    run_scan(2, 1, 1'b1, -1);

    fdel = '{0, 3, 0, 0, 0, 0};
    run_scan(2, 1, 1'b1, -1);

    fsad = '{16};
    fdel = '{0};
    run_scan(0, 0, 1'b1, -1);

    fsad = '{9, 2, 1, 1, 1, 1};
    fdel = '{0, 1, 0, 0, 0, 0};
    run_scan(2, 1, 1'b1, 1);
    fsad = '{100, 100, 100, 100, 100, 100};
    fdel = '{0, 0, 0, 0, 0, 0};
    run_scan(2, 1, 1'b1, -1);

    @(negedge clk);
    i_start = 1'b1;
    i_abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    chk("sa_busy", o_busy, 0);
    chk("sa_req", o_req, 0);
    chk("sa_count", o_count, 6);

    @(negedge clk);
    i_xmax = 3;
    i_ymax = 3;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_ack = 1'b1;
    i_sad = 5;
    repeat (5) @(negedge clk);
    i_ack = 1'b0;
    chk("mid_busy", o_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst",
        {o_req, o_busy, o_done, o_x, o_y, o_best_x, o_best_y},
        '0);
    chk("async_sad", o_best_sad, 0);
    chk("async_count", o_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", o_busy, 0);

    for (int t = 0; t < 30; t++)
      run_scan(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
               1'b0, -1);

    for (int t = 0; t < 20; t++) begin
      int xm, ym;
      xm = int'($urandom_range(0, 5));
      ym = int'($urandom_range(0, 5));
      build(xm, ym);
      s_xm = COORD_W'(xm);
      s_ym = COORD_W'(ym);
      for (int i = 0; i < px.size(); i++) begin
        s_x = COORD_W'(px[i]);
        s_y = COORD_W'(py[i]);
        #1;
        if (i == px.size() - 1) begin
          chk("ss_last", s_last, 1);
        end else begin
          chk("ss_last0", s_last, 0);
          chk("ss_nx", s_nx, px[i + 1]);
          chk("ss_ny", s_ny, py[i + 1]);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
